// File: rtl/mem_access.sv
// mem_access: load/store unit running one AXI4-Lite read or write per request,
// returning lane-aligned, sign/zero-extended load data or store completion.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] lane_q, lane_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d, bready_q, bready_d, err_q, err_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic illegal, misaligned;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0] st_strb;
  logic [DATA_W-1:0] st_data, ld_shift, ld_data;
  // Stores only support B/H/W; the unsigned encodings are load-only.
  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && |req_addr[1:0]);
  assign bus_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign st_strb = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                   req_funct3[1:0] == 2'b01 ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
  assign st_data = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                   req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign ld_shift = axi_rdata >> {lane_q, 3'b000};
  assign ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_shift[7]}}, ld_shift[7:0]} :
                   f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_shift[15]}}, ld_shift[15:0]} : axi_rdata;
  always_comb begin
    state_d = state_q;
    f3_d = f3_q;
    lane_d = lane_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    araddr_d = araddr_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        f3_d = req_funct3;
        lane_d = req_addr[1:0];
        err_d = illegal || misaligned;
        if (illegal || misaligned) state_d = FIN;
        else if (req_we) begin
          state_d = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d = 1'b1;
          awaddr_d = bus_addr;
          wdata_d = st_data;
          wstrb_d = st_strb;
        end else begin
          state_d = RD_ADDR;
          arvalid_d = 1'b1;
          araddr_d = bus_addr;
        end
      end
      RD_ADDR: if (axi_arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (axi_rvalid) begin
        rready_d = 1'b0;
        err_d = |axi_rresp;
        rdata_d = |axi_rresp ? '0 : ld_data;
        state_d = FIN;
      end
      WR_REQ: begin
        // Address and data channels complete independently in any order.
        awvalid_d = awvalid_q && !axi_awready;
        wvalid_d = wvalid_q && !axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (axi_bvalid) begin
        bready_d = 1'b0;
        err_d = |axi_bresp;
        state_d = FIN;
      end
      FIN: begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q <= '0;
      lane_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      araddr_q <= '0;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q <= f3_d;
      lane_q <= lane_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      araddr_q <= araddr_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign done = state_q == FIN;
  assign err = err_q;
  assign rdata = rdata_q;
  assign axi_araddr = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready = rready_q;
  assign axi_awaddr = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata = wdata_q;
  assign axi_wstrb = wstrb_q;
  assign axi_wvalid = wvalid_q;
  assign axi_bready = bready_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access with a simple AXI4-Lite slave.
module tb_mem_access;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic done, err;
  logic [31:0] rdata, axi_araddr, axi_awaddr, axi_wdata;
  logic axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
  logic [3:0] axi_wstrb;
  logic ar_en = 1'b1;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_rresp = '0, s_bresp = '0;
  logic one = 1'b1;
  int w_delay = 0, w_cnt = 0, cyc = 0;
  int ar_cnt = 0, arv_cyc = 0, aw_cnt = 0, b_cnt = 0, aw_t = 0, w_t = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0] last_wstrb = '0;
  int checks = 0, failures = 0;
  typedef struct {logic e_err; logic [31:0] e_rd; bit chk_rd;} exp_t;
  exp_t sb[$];

  mem_access dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(ar_en),
    .axi_rdata(s_rdata), .axi_rresp(s_rresp), .axi_rvalid(one), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(one),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(w_cnt >= w_delay),
    .axi_bresp(s_bresp), .axi_bvalid(one), .axi_bready(axi_bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi_wvalid && !(w_cnt >= w_delay)) w_cnt <= w_cnt + 1;
    else if (!axi_wvalid) w_cnt <= 0;
    if (axi_arvalid) arv_cyc <= arv_cyc + 1;
    if (axi_arvalid && ar_en) begin ar_cnt <= ar_cnt + 1; last_araddr <= axi_araddr; end
    if (axi_awvalid) begin aw_cnt <= aw_cnt + 1; aw_t <= cyc; last_awaddr <= axi_awaddr; end
    if (axi_wvalid && w_cnt >= w_delay) begin w_t <= cyc; last_wdata <= axi_wdata; last_wstrb <= axi_wstrb; end
    if (axi_bready) b_cnt <= b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic e_err, input logic [31:0] e_rd, input bit chk_rd, input int e_lat);
    int lat;
    exp_t e;
    sb.push_back('{e_err, e_rd, chk_rd});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!done && lat < 40);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e.e_err});
    if (e.chk_rd) chk({tag, "_rdata"}, rdata, e.e_rd);
    chk({tag, "_lat"}, lat, e_lat);
  endtask

  initial begin
    int a0, aw0, b0;
    repeat (2) @(posedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_valids", {27'b0, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wstrb", {28'b0, axi_wstrb}, 32'd0);
    @(negedge clk) rst = 1'b0;

    s_rdata = 32'h80FF_1234;
    run("lb", 1'b0, 3'b000, 32'h103, 0, 1'b0, 32'hFFFF_FF80, 1, 3);
    chk("lb_araddr", last_araddr, 32'h100);
    run("lbu", 1'b0, 3'b100, 32'h101, 0, 1'b0, 32'h0000_0012, 1, 3);
    s_rdata = 32'h8001_0000;
    run("lhu", 1'b0, 3'b101, 32'h102, 0, 1'b0, 32'h0000_8001, 1, 3);
    run("lh", 1'b0, 3'b001, 32'h102, 0, 1'b0, 32'hFFFF_8001, 1, 3);
    s_rdata = 32'hDEAD_BEEF;
    run("lw", 1'b0, 3'b010, 32'h10C, 0, 1'b0, 32'hDEAD_BEEF, 1, 3);
    chk("lw_araddr", last_araddr, 32'h10C);

    w_delay = 2; aw0 = aw_cnt; b0 = b_cnt;
    run("sh", 1'b1, 3'b001, 32'h206, 32'h0000_ABCD, 1'b0, 0, 0, 5);
    chk("sh_awaddr", last_awaddr, 32'h204);
    chk("sh_wstrb", {28'b0, last_wstrb}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_aw_before_w", w_t - aw_t, 2);
    chk("sh_aw_once", aw_cnt - aw0, 1);
    chk("sh_b_once", b_cnt - b0, 1);
    w_delay = 0;
    run("sb", 1'b1, 3'b000, 32'h203, 32'h1234_565A, 1'b0, 0, 0, 3);
    chk("sb_wstrb", {28'b0, last_wstrb}, 32'h8);
    chk("sb_wdata", last_wdata, 32'h5A5A_5A5A);
    chk("sb_awaddr", last_awaddr, 32'h200);
    run("sw", 1'b1, 3'b010, 32'h208, 32'h1234_5678, 1'b0, 0, 0, 3);
    chk("sw_wstrb", {28'b0, last_wstrb}, 32'hF);
    chk("sw_wdata", last_wdata, 32'h1234_5678);

    a0 = arv_cyc; aw0 = aw_cnt;
    run("lw_mis", 1'b0, 3'b010, 32'h101, 0, 1'b1, 0, 0, 1);
    run("lh_mis", 1'b0, 3'b001, 32'h103, 0, 1'b1, 0, 0, 1);
    run("ld_f3_011", 1'b0, 3'b011, 32'h100, 0, 1'b1, 0, 0, 1);
    run("st_f3_100", 1'b1, 3'b100, 32'h100, 0, 1'b1, 0, 0, 1);
    chk("mis_no_ar", arv_cyc - a0, 0);
    chk("mis_no_aw", aw_cnt - aw0, 0);

    s_rresp = 2'b10;
    run("rresp", 1'b0, 3'b010, 32'h110, 0, 1'b1, 32'h0, 1, 3);
    s_rresp = 2'b00; s_bresp = 2'b11;
    run("bresp", 1'b1, 3'b010, 32'h110, 32'h1, 1'b1, 0, 0, 3);
    s_bresp = 2'b00;

    ar_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    chk("abort_arvalid_pre", {31'b0, axi_arvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_arvalid", {31'b0, axi_arvalid}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk) rst = 1'b0;
    ar_en = 1'b1;
    @(negedge clk);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    s_rdata = 32'hCAFE_F00D;
    run("post_rst", 1'b0, 3'b010, 32'h304, 0, 1'b0, 32'hCAFE_F00D, 1, 3);
    chk("post_rst_araddr", last_araddr, 32'h304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
